// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage core's pipeline sequencing control.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0]  REG_ZERO  = 4'd0;
    // IF/ID flush loads this encoding so the squashed slot has no side effects
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register an EXE-stage load writes.
// Purely combinational; r0 never produces a hazard.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_ren,
    input  logic [3:0] ex_reg_waddr,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_reg_waddr);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_reg_waddr);
    assign load_use = ex_mem_ren && (ex_reg_waddr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, IF/ID flush and ID/EXE bubble from
// memory waits, taken branches and load-use hazards; outputs act in the same cycle.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_ren,
    input  logic [3:0]  ex_reg_waddr,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_exe_en,
    output logic        id_exe_bubble,
    output logic        exe_mem_en,
    output logic [15:0] stall_cycles,
    output logic        mem_err
);

    localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WAIT_LIMIT   = 16'(MEM_TIMEOUT);

    state_t      state, state_n;
    logic [1:0]  flush_cnt, flush_cnt_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic        err_set;
    logic        load_use;
    logic        mem_stall;
    logic        timeout;
    logic        released;
    logic        frozen;

    hazard_detect u_hazard_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_mem_ren   (ex_mem_ren),
        .ex_reg_waddr (ex_reg_waddr),
        .load_use     (load_use)
    );

    assign mem_stall = mem_req && !mem_ack;
    assign timeout   = (state == MEM_WAIT) && (wait_cnt >= WAIT_LIMIT);
    assign released  = (state == MEM_WAIT) && (mem_ack || timeout);
    // A pending wait starts the freeze in its first cycle; in MEM_WAIT only ack/timeout lifts it
    assign frozen    = (state == MEM_WAIT) ? !released : mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
            wait_cnt  <= 16'd0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
            wait_cnt  <= wait_cnt_n;
            if (err_set) mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        wait_cnt_n  = wait_cnt;
        err_set     = 1'b0;
        if (frozen) begin
            state_n    = MEM_WAIT;
            wait_cnt_n = (state == MEM_WAIT) ? wait_cnt + 16'd1 : 16'd1;
        end else begin
            wait_cnt_n = 16'd0;
            err_set    = released && !mem_ack;
            if (ex_branch_taken) begin
                state_n     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                flush_cnt_n = (FLUSH_CYCLES > 1) ? FLUSH_RELOAD : 2'd0;
            end else if (state == FLUSH) begin
                flush_cnt_n = flush_cnt - 2'd1;
                state_n     = (flush_cnt <= 2'd1) ? RUN : FLUSH;
            end else if (state == MEM_WAIT) begin
                state_n = (flush_cnt != 2'd0) ? FLUSH : RUN;
            end else begin
                state_n = RUN;
            end
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        if (rst) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (!frozen) begin
            pc_en      = 1'b1;
            if_id_en   = 1'b1;
            id_exe_en  = 1'b1;
            exe_mem_en = 1'b1;
            if (ex_branch_taken || state == FLUSH) begin
                if_id_flush   = 1'b1;
                id_exe_bubble = 1'b1;
            end else if (load_use) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_exe_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (!pc_en && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  id_rs1 = '0, id_rs2 = '0, ex_reg_waddr = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, ex_mem_ren = 1'b0;
    logic        ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_mem_en;
    logic [15:0] stall_cycles;
    logic        mem_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_stall = 16'd0;
    logic        exp_merr = 1'b0;
    logic [5:0]  exp_q[$];

    // {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_bubble}
    localparam logic [5:0] RUNV = 6'b111100;
    localparam logic [5:0] FRZ  = 6'b000000;
    localparam logic [5:0] BR   = 6'b111111;
    localparam logic [5:0] LU   = 6'b001101;
    localparam logic [5:0] RSTV = 6'b000011;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_ren(ex_mem_ren), .ex_reg_waddr(ex_reg_waddr),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_exe_en(id_exe_en), .id_exe_bubble(id_exe_bubble), .exe_mem_en(exe_mem_en),
        .stall_cycles(stall_cycles), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r,
                        input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2,
                        input logic ren, input logic [3:0] wa,
                        input logic br, input logic req, input logic ack,
                        input logic [5:0] e, input string tag);
        logic [5:0] want;
        logic [5:0] got;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        ex_mem_ren = ren; ex_reg_waddr = wa; ex_branch_taken = br;
        mem_req = req; mem_ack = ack;
        exp_q.push_back(e);
        @(negedge clk);
        want = exp_q.pop_front();
        got  = {pc_en, if_id_en, id_exe_en, exe_mem_en, if_id_flush, id_exe_bubble};
        if (r) begin
            exp_stall = 16'd0;
            exp_merr  = 1'b0;
        end
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s ctl: got %b want %b", tag, got, want);
        end
        vectors++;
        assert (stall_cycles === exp_stall) else begin
            miscompares++;
            $error("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, exp_stall);
        end
        vectors++;
        assert (mem_err === exp_merr) else begin
            miscompares++;
            $error("FAIL %s mem_err: got %b want %b", tag, mem_err, exp_merr);
        end
        if (!r && !want[5] && exp_stall != 16'hFFFF) exp_stall++;
    endtask

    initial begin
        //   rst rs1   u1  rs2   u2  ren wa    br  req ack  expect tag
        step(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RSTV, "reset_hold");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "run_idle");
        // load-use on rs2, then r0 destination and unused operand cases
        step(0, 4'd1, 1, 4'd5, 1, 1, 4'd5, 0, 0, 0, LU,   "lu_rs2");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "lu_one_cycle");
        step(0, 4'd0, 1, 4'd0, 1, 1, 4'd0, 0, 0, 0, RUNV, "lu_r0");
        step(0, 4'd7, 0, 4'd2, 1, 1, 4'd7, 0, 0, 0, RUNV, "lu_rs1_unused");
        step(0, 4'd7, 1, 4'd2, 0, 1, 4'd7, 0, 0, 0, LU,   "lu_rs1");
        step(0, 4'd7, 1, 4'd2, 0, 1, 4'd6, 0, 0, 0, RUNV, "lu_no_match");
        // taken branch with two flush cycles
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0, BR,   "br_cycle");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, BR,   "br_flush2");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "br_back_run");
        // three-cycle memory wait then ack
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "mw_entry");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "mw_hold1");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "mw_hold2");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 1, RUNV, "mw_ack");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "mw_after");
        // wait, branch and load-use together: freeze, then branch wins on release
        step(0, 4'd0, 0, 4'd5, 1, 1, 4'd5, 1, 1, 0, FRZ,  "sim_entry");
        step(0, 4'd0, 0, 4'd5, 1, 1, 4'd5, 1, 1, 0, FRZ,  "sim_hold");
        step(0, 4'd0, 0, 4'd5, 1, 1, 4'd5, 1, 1, 1, BR,   "sim_release");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, BR,   "sim_flush2");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "sim_run");
        // timeout after four frozen cycles, mem_err sticky
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "to_entry");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "to_hold1");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "to_hold2");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "to_hold3");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, RUNV, "to_release");
        exp_merr = 1'b1;
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "to_err_set");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0, BR,   "to_err_sticky");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, BR,   "to_err_flush");
        // reset while frozen
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "rst_mw_entry");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, FRZ,  "rst_mw_hold");
        step(1, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0, RSTV, "rst_mid_wait");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "rst_release");
        step(0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, RUNV, "rst_idle");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
